// File: rtl/pressure_sample_sequencer_pkg.sv
// Shared types and constants for the pressure sample sequencer and its
// calibration-engine interface.
package pressure_pkg;

  localparam int RAW_W_DEF = 12;
  localparam int RES_W_DEF = 16;
  // Cycles from the engine seeing start to done being visible.
  localparam int CAL_LAT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pressure_sample_sequencer_if.sv
// Bundle of ADC, calibration-engine, result-consumer and flag signals.
// The master side is the sequencer; the slave side is its environment.
interface pressure_sample_sequencer_if #(
  parameter int RAW_W = 12,
  parameter int RES_W = 16
);

  logic             trig;
  logic             sample_req;
  logic             adc_valid;
  logic [RAW_W-1:0] praw_in;
  logic [RAW_W-1:0] traw_in;
  logic [RAW_W-1:0] praw;
  logic [RAW_W-1:0] traw;
  logic             start;
  logic             done;
  logic [RES_W-1:0] result_in;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             overrun;
  logic             timeout_err;
  logic             clr_flags;

  modport master (
    input  trig, adc_valid, praw_in, traw_in, done, result_in, res_ready, clr_flags,
    output sample_req, praw, traw, start, res_valid, res_data, overrun, timeout_err
  );

  modport slave (
    output trig, adc_valid, praw_in, traw_in, done, result_in, res_ready, clr_flags,
    input  sample_req, praw, traw, start, res_valid, res_data, overrun, timeout_err
  );

endinterface

// File: rtl/pressure_sample_sequencer_result_fifo2.sv
// Two-entry result buffer. The head entry sits in a register so the
// consumer sees registered data; a pop frees a slot for a same-cycle push.
module result_fifo2 #(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [RES_W-1:0] din_i,
  output logic [RES_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [RES_W-1:0] head_q, head_d;
  logic [RES_W-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop_i & (cnt_q != 2'd0);
  assign push_ok = push_i & ((cnt_q != 2'd2) | pop_ok);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_ok) begin
          head_d = din_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop_ok && push_ok) begin
          head_d = din_i;
        end else if (pop_ok) begin
          cnt_d = 2'd0;
        end else if (push_ok) begin
          tail_d = din_i;
          cnt_d  = 2'd2;
        end
      end
      default: begin
        if (pop_ok) begin
          head_d = tail_q;
          if (push_ok) tail_d = din_i;
          else         cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = head_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/pressure_sample_sequencer.sv
// Requests raw Praw/Traw pairs periodically or on trigger, runs the
// calibration engine once per pair and buffers the compensated results.
//
// state | meaning
// IDLE  | waiting for a period tick or manual trigger
// REQ   | sample_req high, waiting for adc_valid to latch the pair
// START | one-cycle start pulse to the engine, wait counter cleared
// WAIT  | waiting for done, bounded by TIMEOUT cycles
module pressure_sample_sequencer
  import pressure_pkg::*;
#(
  parameter int RAW_W   = RAW_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  pressure_sample_sequencer_if.master bus
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [WW-1:0] TMO_VAL  = WW'(TIMEOUT);

  seq_state_t       state_q, state_d;
  logic [PW-1:0]    period_q, period_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [RAW_W-1:0] praw_q, praw_d;
  logic [RAW_W-1:0] traw_q, traw_d;
  logic             overrun_q, overrun_d;
  logic             tmo_q, tmo_d;
  logic             tick, push, pop, drop, tmo_hit;
  logic             req_c, start_c;
  logic             fifo_full, fifo_empty;
  logic [RES_W-1:0] fifo_dout;

  // Free-running: ticks landing outside IDLE are simply lost.
  assign tick     = (period_q == PER_LAST);
  assign period_d = tick ? '0 : period_q + PW'(1);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    praw_d  = praw_q;
    traw_d  = traw_q;
    push    = 1'b0;
    tmo_hit = 1'b0;
    req_c   = 1'b0;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || bus.trig) state_d = REQ;
      end
      REQ: begin
        req_c = 1'b1;
        if (bus.adc_valid) begin
          praw_d  = bus.praw_in;
          traw_d  = bus.traw_in;
          state_d = START;
        end
      end
      START: begin
        start_c = 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // wait_d is the 1-based index of the current WAIT cycle.
        wait_d = wait_q + WW'(1);
        if (bus.done) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (wait_d == TMO_VAL) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop       = ~fifo_empty & bus.res_ready;
  assign drop      = push & fifo_full & ~pop;
  assign overrun_d = drop | (overrun_q & ~bus.clr_flags);
  assign tmo_d     = tmo_hit | (tmo_q & ~bus.clr_flags);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      wait_q    <= '0;
      praw_q    <= '0;
      traw_q    <= '0;
      overrun_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      wait_q    <= wait_d;
      praw_q    <= praw_d;
      traw_q    <= traw_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
    end
  end

  result_fifo2 #(.RES_W(RES_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.result_in),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.sample_req  = req_c;
  assign bus.start       = start_c;
  assign bus.praw        = praw_q;
  assign bus.traw        = traw_q;
  assign bus.res_valid   = ~fifo_empty;
  assign bus.res_data    = fifo_dout;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_pressure_sample_sequencer.sv
// Directed bench for pressure_sample_sequencer with an engine model and a
// scoreboard of expected buffered results.
module tb_pressure_sample_sequencer;
  import pressure_pkg::*;

  localparam int RAW_W   = 12;
  localparam int RES_W   = 16;
  localparam int PERIOD  = 40;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pressure_sample_sequencer_if #(.RAW_W(RAW_W), .RES_W(RES_W)) bus ();

  pressure_sample_sequencer #(
    .RAW_W(RAW_W), .RES_W(RES_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [RES_W-1:0] sb [$];

  // Engine model: done drops the cycle after start and rises CAL_LAT cycles
  // after start; it then holds until the next start.
  logic             eng_done = 1'b0;
  logic [RES_W-1:0] eng_res  = '0;
  logic [2:0]       eng_cnt  = '0;
  logic             eng_hang = 1'b0;
  logic [RES_W-1:0] eng_result = '0;
  int               start_cnt = 0;

  assign bus.done      = eng_done;
  assign bus.result_in = eng_res;

  always @(posedge clk) begin
    if (bus.start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      eng_done  <= 1'b0;
      eng_cnt   <= eng_hang ? 3'd0 : 3'(CAL_LAT - 1);
    end else if (eng_cnt != 3'd0) begin
      eng_cnt <= eng_cnt - 3'd1;
      if (eng_cnt == 3'd1) begin
        eng_done <= 1'b1;
        eng_res  <= eng_result;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample_req"}, 32'(bus.sample_req), 32'd0);
    check({tag, "_start"},      32'(bus.start), 32'd0);
    check({tag, "_praw"},       32'(bus.praw), 32'd0);
    check({tag, "_traw"},       32'(bus.traw), 32'd0);
    check({tag, "_res_valid"},  32'(bus.res_valid), 32'd0);
    check({tag, "_res_data"},   32'(bus.res_data), 32'd0);
    check({tag, "_overrun"},    32'(bus.overrun), 32'd0);
    check({tag, "_timeout"},    32'(bus.timeout_err), 32'd0);
  endtask

  // Returns one cycle after adc_valid (the START cycle).
  task automatic request(input logic [RAW_W-1:0] p, input logic [RAW_W-1:0] t, input bit use_trig);
    int n = 0;
    if (use_trig) begin
      bus.trig = 1'b1;
      step();
      bus.trig = 1'b0;
    end
    while (bus.sample_req !== 1'b1 && n < PERIOD + 2) begin
      step();
      n++;
    end
    check("sample_req", 32'(bus.sample_req), 32'd1);
    bus.praw_in   = p;
    bus.traw_in   = t;
    bus.adc_valid = 1'b1;
    step();
    bus.adc_valid = 1'b0;
    bus.praw_in   = ~p;
    bus.traw_in   = ~t;
    check("start_pulse", 32'(bus.start), 32'd1);
    check("praw_latched", 32'(bus.praw), 32'(p));
    check("traw_latched", 32'(bus.traw), 32'(t));
  endtask

  task automatic drain_one(input string tag);
    int n = 0;
    logic [RES_W-1:0] exp;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) exp = sb.pop_front();
    else                exp = '1;
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
  endtask

  initial begin
    logic [RES_W-1:0] exp_head;
    bus.trig      = 1'b0;
    bus.adc_valid = 1'b0;
    bus.praw_in   = '0;
    bus.traw_in   = '0;
    bus.res_ready = 1'b0;
    bus.clr_flags = 1'b0;
    rst           = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Periodic sample: first tick lands PERIOD cycles after reset release.
    repeat (PERIOD - 1) step();
    check("pre_tick_idle", 32'(bus.sample_req), 32'd0);
    step();
    check("tick_req", 32'(bus.sample_req), 32'd1);
    eng_result = 16'hBEEF;
    sb.push_back(16'hBEEF);
    request(12'h123, 12'h456, 1'b0);
    step();
    check("start_one_cycle", 32'(bus.start), 32'd0);
    repeat (3) step();
    check("no_early_result", 32'(bus.res_valid), 32'd0);
    step();
    check("result_latency", 32'(bus.res_valid), 32'd1);
    check("praw_held", 32'(bus.praw), 32'h123);
    check("traw_held", 32'(bus.traw), 32'h456);
    check("single_start", 32'(start_cnt), 32'd1);
    drain_one("periodic");
    check("periodic_empty", 32'(bus.res_valid), 32'd0);

    // Stale done: engine still shows done=1 with 0xBEEF until the next start.
    eng_result = 16'h1234;
    sb.push_back(16'h1234);
    request(12'h0AB, 12'h0CD, 1'b1);
    check("stale_not_in_req", 32'(bus.res_valid), 32'd0);
    step();
    check("stale_not_in_start", 32'(bus.res_valid), 32'd0);
    repeat (4) step();
    drain_one("stale_new_value");
    check("stale_single_entry", 32'(bus.res_valid), 32'd0);

    // Timeout: engine never completes.
    eng_hang = 1'b1;
    request(12'h321, 12'h654, 1'b1);
    repeat (TIMEOUT) step();
    check("tmo_not_yet", 32'(bus.timeout_err), 32'd0);
    step();
    check("tmo_set", 32'(bus.timeout_err), 32'd1);
    check("tmo_no_push", 32'(bus.res_valid), 32'd0);
    eng_hang   = 1'b0;
    eng_result = 16'h0777;
    sb.push_back(16'h0777);
    request(12'h111, 12'h222, 1'b0);
    repeat (5) step();
    drain_one("after_tmo");
    check("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    pulse_clr();
    check("tmo_cleared", 32'(bus.timeout_err), 32'd0);

    // Overrun: three completions with no consumer.
    eng_result = 16'd1; sb.push_back(16'd1);
    request(12'h001, 12'h001, 1'b1); repeat (5) step();
    eng_result = 16'd2; sb.push_back(16'd2);
    request(12'h002, 12'h002, 1'b1); repeat (5) step();
    check("ovr_not_at_two", 32'(bus.overrun), 32'd0);
    eng_result = 16'd3;
    request(12'h003, 12'h003, 1'b1); repeat (5) step();
    check("ovr_set", 32'(bus.overrun), 32'd1);
    drain_one("ovr_first");
    drain_one("ovr_second");
    check("ovr_drained", 32'(bus.res_valid), 32'd0);
    pulse_clr();
    check("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Full buffer with pop and push in the same cycle.
    eng_result = 16'd1; sb.push_back(16'd1);
    request(12'h004, 12'h004, 1'b1); repeat (5) step();
    eng_result = 16'd2; sb.push_back(16'd2);
    request(12'h005, 12'h005, 1'b1); repeat (5) step();
    eng_result = 16'd4; sb.push_back(16'd4);
    request(12'h006, 12'h006, 1'b1);
    repeat (4) step();
    exp_head = sb.pop_front();
    check("simul_head", 32'(bus.res_data), 32'(exp_head));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("simul_no_overrun", 32'(bus.overrun), 32'd0);
    drain_one("simul_first");
    drain_one("simul_second");
    check("simul_drained", 32'(bus.res_valid), 32'd0);

    // Reset in the middle of WAIT.
    eng_result = 16'hAAAA; sb.push_back(16'hAAAA);
    request(12'h007, 12'h008, 1'b1); repeat (5) step();
    eng_result = 16'h5555;
    request(12'h009, 12'h00A, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check_reset_outputs("mid_wait_rst");
    repeat (3) step();
    check("rst_no_push", 32'(bus.res_valid), 32'd0);
    check("rst_idle", 32'(bus.sample_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pressure_sample_sequencer.md
# pressure_sample_sequencer

Host-side sequencer that drives the compensated-pressure calibration engine from the requesting end. Every `PERIOD` cycles (or on a manual trigger) it requests one raw Praw/Traw pair from the ADC front end, holds the pair stable for the engine's datapath, pulses the engine's `start`, and waits for `done`. On completion it pushes the 16-bit compensated result into a 2-entry output buffer drained by a valid/ready consumer.

## Interface
Parameters:
- `RAW_W`, default 12: width of the Praw/Traw samples.
- `RES_W`, default 16: width of the calibration result.
- `PERIOD`, default 1000: sample interval in cycles; legal range ≥ 8.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT before the sequencer declares an error.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `trig` in 1: manual sample request; accepted only in IDLE.
- `sample_req` out 1: request to the ADC; held high until `adc_valid`.
- `adc_valid` in 1: ADC sample strobe.
- `praw_in` in RAW_W: raw pressure from the ADC.
- `traw_in` in RAW_W: raw temperature from the ADC.
- `praw` out RAW_W: held Praw, driven to the engine datapath.
- `traw` out RAW_W: held Traw, driven to the engine datapath.
- `start` out 1: one-cycle start pulse to the engine.
- `done` in 1: engine done level. It stays high after completion until the next start.
- `result_in` in RES_W: engine store register value.
- `res_valid` out 1: output buffer is non-empty.
- `res_ready` in 1: consumer accepts the head entry.
- `res_data` out RES_W: head of the output buffer.
- `overrun` out 1: sticky flag; a result was dropped because the buffer was full.
- `timeout_err` out 1: sticky flag; the engine did not reach `done` within TIMEOUT.
- `clr_flags` in 1: synchronous clear of both sticky flags.

## Operation
State machine states: IDLE, REQ, START, WAIT.
- **IDLE**
  - The period counter counts 0..PERIOD-1 and always runs, including outside IDLE.
  - A tick occurs when the counter equals PERIOD-1.
  - On a tick or `trig`, go to REQ. Ticks that occur outside IDLE are lost; they are not queued.
- **REQ**
  - `sample_req`=1.
  - On `adc_valid`, latch `praw_in`/`traw_in` into `praw`/`traw` and go to START.
- **START**
  - `start`=1 for exactly this one cycle.
  - Clear the wait counter, then go to WAIT.
- **WAIT**
  - Increment the wait counter each cycle.
  - If `done`=1, capture `result_in` and push it to the buffer, then go to IDLE.
  - Else, if the wait counter equals TIMEOUT, set `timeout_err` and go to IDLE with no push.
- **Buffer and flags**
  - The buffer is a 2-entry FIFO.
  - A push while full drops the new value and sets `overrun`.
  - A push and a pop in the same cycle while full is legal: the pop frees the slot and the push succeeds.
  - A push while empty appears on `res_data` the next cycle.
- **Held samples:** `praw`/`traw` stay unchanged from the latch until the next `adc_valid` in REQ.
- **Stale `done`:** stale `done`=1 during IDLE, REQ or START is ignored. Only WAIT samples `done`. The engine drops `done` the cycle after `start`.
- **`clr_flags`:** when asserted in the same cycle as a flag-set event, the set wins.

## Timing
- Reset values: state=IDLE, period counter=0.
  - Outputs: `sample_req`=0, `start`=0, `praw`=`traw`=0, `res_valid`=0, `res_data`=0, `overrun`=0, `timeout_err`=0.
  - The buffer is emptied.
- Reset asserted mid-operation aborts any in-flight request or wait with no push. The engine is reset separately.
- Cycle sequence: `adc_valid` at cycle t → `start`=1 at t+1 → WAIT from t+2.
- With the 4-state engine, `done` is seen at t+5. The push is registered at that edge, so `res_valid`=1 at t+6.
- Minimum sample-to-result latency: 6 cycles after `adc_valid`.
- Timeout fires on the TIMEOUT-th WAIT cycle without `done`.
- `res_data`/`res_valid` come from registers. A pop takes effect at the clock edge where `res_valid`&&`res_ready`.

## Structure
- Shared package `pressure_pkg`:
  - `seq_state_t` enum (IDLE, REQ, START, WAIT).
  - RAW_W/RES_W default constants.
  - The engine latency constant CAL_LAT=4.
- One sub-module, `result_fifo2`: 2-entry synchronous FIFO with push/pop/full/empty, parameterised by RES_W.
- Everything else is the top FSM plus two counters.

## Test plan
- **Periodic sample:** reset, then `adc_valid` with Praw=0x123, Traw=0x456, engine model returns 0xBEEF after 4 cycles → exactly one `start` pulse; `res_valid`=1 with `res_data`=0xBEEF 6 cycles after `adc_valid`; `praw`=0x123 held throughout.
- **Stale `done`:** engine model holds `done`=1 from the prior run, `trig` pulsed → no capture before WAIT; the captured value is the new result, not the stale one.
- **Timeout:** engine never asserts `done` → `timeout_err`=1 at WAIT cycle 15; no push; next tick starts a fresh request; `clr_flags` clears the flag.
- **Overrun:** `res_ready`=0 across 3 completions with results 1, 2, 3 → buffer holds 1, 2; `overrun`=1; a drain yields 1 then 2.
- **Full with simultaneous pop and push:** buffer full, `res_ready`=1 in the same cycle as a push of 4 → no overrun; drain order 2, 4.
- **Reset mid-WAIT:** `rst` pulsed during WAIT → all outputs return to reset values; no push occurs.
